// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with fill count, almost-full/almost-empty thresholds,
// sticky overflow/underflow flags and a selectable first-word-fall-through read port.
module sync_fifo_flags #(
    parameter int DataSize     = 8,
    parameter int AddrSize     = 3,
    parameter int AFullThresh  = 6,
    parameter int AEmptyThresh = 1,
    parameter int FWFT         = 0
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                Push,
    input  logic                Pop,
    input  logic [DataSize-1:0] DataIn,
    input  logic                ClearErr,
    output logic [DataSize-1:0] DataOut,
    output logic                full,
    output logic                empty,
    output logic                AlmostFull,
    output logic                AlmostEmpty,
    output logic [AddrSize:0]   Count,
    output logic                Overflow,
    output logic                Underflow
);

    localparam int PW    = AddrSize + 1;
    localparam int DEPTH = 1 << AddrSize;
    localparam logic [AddrSize:0] DEPTH_C  = PW'(DEPTH);
    localparam logic [AddrSize:0] AFULL_C  = PW'(AFullThresh);
    localparam logic [AddrSize:0] AEMPTY_C = PW'(AEmptyThresh);

    logic [DataSize-1:0] mem [DEPTH];

    logic [AddrSize:0]   wr_ptr_reg, wr_ptr_next;
    logic [AddrSize:0]   rd_ptr_reg, rd_ptr_next;
    logic [AddrSize:0]   count_reg, count_next;
    logic                full_reg, empty_reg, afull_reg, aempty_reg;
    logic                ovf_reg, ovf_next, unf_reg, unf_next;
    logic                push_ok, pop_ok;
    logic [AddrSize-1:0] wr_addr, rd_addr;

    assign wr_addr = wr_ptr_reg[AddrSize-1:0];
    assign rd_addr = rd_ptr_reg[AddrSize-1:0];

    always_comb begin
        pop_ok      = Pop && !empty_reg;
        // A full FIFO still takes a write when the same cycle frees a slot.
        push_ok     = Push && (!full_reg || pop_ok);
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (push_ok) wr_ptr_next = wr_ptr_reg + PW'(1);
        if (pop_ok)  rd_ptr_next = rd_ptr_reg + PW'(1);
        case ({push_ok, pop_ok})
            2'b10:   count_next = count_reg + PW'(1);
            2'b01:   count_next = count_reg - PW'(1);
            default: count_next = count_reg;
        endcase
        // A new error in the same cycle as ClearErr leaves the flag set.
        ovf_next = (Push && !push_ok) || (ovf_reg && !ClearErr);
        unf_next = (Pop && !pop_ok) || (unf_reg && !ClearErr);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            full_reg   <= 1'b0;
            empty_reg  <= 1'b1;
            afull_reg  <= 1'b0;
            aempty_reg <= 1'b1;
            ovf_reg    <= 1'b0;
            unf_reg    <= 1'b0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            full_reg   <= (wr_ptr_next[AddrSize] != rd_ptr_next[AddrSize]) &&
                          (wr_ptr_next[AddrSize-1:0] == rd_ptr_next[AddrSize-1:0]);
            empty_reg  <= (wr_ptr_next == rd_ptr_next);
            afull_reg  <= (count_next >= AFULL_C);
            aempty_reg <= (count_next <= AEMPTY_C);
            ovf_reg    <= ovf_next;
            unf_reg    <= unf_next;
        end
    end

    always_ff @(posedge Clk) begin
        if (push_ok) mem[wr_addr] <= DataIn;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Shadow of the displayed head word so DataOut holds once drained.
            logic [DataSize-1:0] hold_reg;
            always_ff @(posedge Clk) begin
                if (Reset)           hold_reg <= '0;
                else if (!empty_reg) hold_reg <= mem[rd_addr];
            end
            assign DataOut = empty_reg ? hold_reg : mem[rd_addr];
        end else begin : g_registered
            logic [DataSize-1:0] dout_reg;
            always_ff @(posedge Clk) begin
                if (Reset)       dout_reg <= '0;
                else if (pop_ok) dout_reg <= mem[rd_addr];
            end
            assign DataOut = dout_reg;
        end
    endgenerate

    assign full        = full_reg;
    assign empty       = empty_reg;
    assign AlmostFull  = afull_reg;
    assign AlmostEmpty = aempty_reg;
    assign Count       = count_reg;
    assign Overflow    = ovf_reg;
    assign Underflow   = unf_reg;

    a_not_full_and_empty: assert property (@(posedge Clk) disable iff (Reset)
        !(full_reg && empty_reg));
    a_count_bound: assert property (@(posedge Clk) disable iff (Reset)
        count_reg <= DEPTH_C);
    a_count_ptrs: assert property (@(posedge Clk) disable iff (Reset)
        count_reg == (wr_ptr_reg - rd_ptr_reg));
    a_push_full: assert property (@(posedge Clk) disable iff (Reset)
        (push_ok && full_reg) |-> pop_ok);

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed bench: table of fill/drain/simultaneous vectors on a registered-read
// instance, plus wrap, FWFT and mid-operation reset sequences.
module tb_sync_fifo_flags;

    logic       Clk = 1'b0;
    logic       Reset, ClearErr;
    logic       push0, pop0, push1, pop1;
    logic [7:0] din0, din1, dout0, dout1;
    logic       full0, empty0, af0, ae0, ovf0, unf0;
    logic       full1, empty1, af1, ae1, ovf1, unf1;
    logic [3:0] count0, count1;

    always #5 Clk = ~Clk;

    sync_fifo_flags #(.DataSize(8), .AddrSize(3), .AFullThresh(6), .AEmptyThresh(1), .FWFT(0)) dut0 (
        .Clk(Clk), .Reset(Reset), .Push(push0), .Pop(pop0), .DataIn(din0), .ClearErr(ClearErr),
        .DataOut(dout0), .full(full0), .empty(empty0), .AlmostFull(af0), .AlmostEmpty(ae0),
        .Count(count0), .Overflow(ovf0), .Underflow(unf0));

    sync_fifo_flags #(.DataSize(8), .AddrSize(3), .AFullThresh(6), .AEmptyThresh(1), .FWFT(1)) dut1 (
        .Clk(Clk), .Reset(Reset), .Push(push1), .Pop(pop1), .DataIn(din1), .ClearErr(ClearErr),
        .DataOut(dout1), .full(full1), .empty(empty1), .AlmostFull(af1), .AlmostEmpty(ae1),
        .Count(count1), .Overflow(ovf1), .Underflow(unf1));

    // flags packed as {full, empty, AlmostFull, AlmostEmpty, Overflow, Underflow}
    typedef struct {
        logic       push;
        logic       pop;
        logic [7:0] din;
        logic       clr;
        logic [3:0] cnt;
        logic [7:0] dout;
        logic [5:0] flags;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    function automatic vec_t mk(logic p, logic o, logic [7:0] d, logic c,
                                logic [3:0] n, logic [7:0] q, logic [5:0] f);
        vec_t v;
        v.push = p; v.pop = o; v.din = d; v.clr = c;
        v.cnt = n; v.dout = q; v.flags = f;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
        end else begin
            $display("ok   %s[%0d] = %0h", name, idx, act);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        logic [7:0] q[$];
        logic [7:0] exp_b;
        int  sent, recv, cyc;
        bit  p, o, po, pu, seen0, seen1;

        Reset = 1'b1; ClearErr = 1'b0;
        push0 = 1'b0; pop0 = 1'b0; din0 = '0;
        push1 = 1'b0; pop1 = 1'b0; din1 = '0;
        tick();
        tick();
        chk("rst_count", 0, count0, 4'd0);
        chk("rst_flags", 0, {full0, empty0, af0, ae0, ovf0, unf0}, 6'b010100);
        chk("rst_dout", 0, dout0, 8'd0);
        chk("rst_dout_fwft", 0, dout1, 8'd0);
        chk("rst_empty_fwft", 0, empty1, 1'b1);
        Reset = 1'b0;

        // fill 10..17, overflow with 99
        vecs.push_back(mk(1,0,8'd10,0, 1, 0, 6'b000100));
        vecs.push_back(mk(1,0,8'd11,0, 2, 0, 6'b000000));
        vecs.push_back(mk(1,0,8'd12,0, 3, 0, 6'b000000));
        vecs.push_back(mk(1,0,8'd13,0, 4, 0, 6'b000000));
        vecs.push_back(mk(1,0,8'd14,0, 5, 0, 6'b000000));
        vecs.push_back(mk(1,0,8'd15,0, 6, 0, 6'b001000));
        vecs.push_back(mk(1,0,8'd16,0, 7, 0, 6'b001000));
        vecs.push_back(mk(1,0,8'd17,0, 8, 0, 6'b101000));
        vecs.push_back(mk(1,0,8'd99,0, 8, 0, 6'b101010));
        // drain, underflow, clear
        vecs.push_back(mk(0,1,8'd0,0, 7, 8'd10, 6'b001010));
        vecs.push_back(mk(0,1,8'd0,0, 6, 8'd11, 6'b001010));
        vecs.push_back(mk(0,1,8'd0,0, 5, 8'd12, 6'b000010));
        vecs.push_back(mk(0,1,8'd0,0, 4, 8'd13, 6'b000010));
        vecs.push_back(mk(0,1,8'd0,0, 3, 8'd14, 6'b000010));
        vecs.push_back(mk(0,1,8'd0,0, 2, 8'd15, 6'b000010));
        vecs.push_back(mk(0,1,8'd0,0, 1, 8'd16, 6'b000110));
        vecs.push_back(mk(0,1,8'd0,0, 0, 8'd17, 6'b010110));
        vecs.push_back(mk(0,1,8'd0,0, 0, 8'd17, 6'b010111));
        vecs.push_back(mk(0,0,8'd0,1, 0, 8'd17, 6'b010100));
        // refill 30..37, push+pop at full, drain
        vecs.push_back(mk(1,0,8'd30,0, 1, 8'd17, 6'b000100));
        vecs.push_back(mk(1,0,8'd31,0, 2, 8'd17, 6'b000000));
        vecs.push_back(mk(1,0,8'd32,0, 3, 8'd17, 6'b000000));
        vecs.push_back(mk(1,0,8'd33,0, 4, 8'd17, 6'b000000));
        vecs.push_back(mk(1,0,8'd34,0, 5, 8'd17, 6'b000000));
        vecs.push_back(mk(1,0,8'd35,0, 6, 8'd17, 6'b001000));
        vecs.push_back(mk(1,0,8'd36,0, 7, 8'd17, 6'b001000));
        vecs.push_back(mk(1,0,8'd37,0, 8, 8'd17, 6'b101000));
        vecs.push_back(mk(1,1,8'd50,0, 8, 8'd30, 6'b101000));
        vecs.push_back(mk(0,1,8'd0,0, 7, 8'd31, 6'b001000));
        vecs.push_back(mk(0,1,8'd0,0, 6, 8'd32, 6'b001000));
        vecs.push_back(mk(0,1,8'd0,0, 5, 8'd33, 6'b000000));
        vecs.push_back(mk(0,1,8'd0,0, 4, 8'd34, 6'b000000));
        vecs.push_back(mk(0,1,8'd0,0, 3, 8'd35, 6'b000000));
        vecs.push_back(mk(0,1,8'd0,0, 2, 8'd36, 6'b000000));
        vecs.push_back(mk(0,1,8'd0,0, 1, 8'd37, 6'b000100));
        vecs.push_back(mk(0,1,8'd0,0, 0, 8'd50, 6'b010100));
        // push+pop at empty: push taken, pop rejected
        vecs.push_back(mk(1,1,8'd60,0, 1, 8'd50, 6'b000101));
        vecs.push_back(mk(0,1,8'd0,0, 0, 8'd60, 6'b010101));
        vecs.push_back(mk(0,0,8'd0,1, 0, 8'd60, 6'b010100));

        for (int i = 0; i < vecs.size(); i++) begin
            push0 = vecs[i].push; pop0 = vecs[i].pop;
            din0 = vecs[i].din;   ClearErr = vecs[i].clr;
            tick();
            chk("vec_count", i, count0, vecs[i].cnt);
            chk("vec_dout", i, dout0, vecs[i].dout);
            chk("vec_flags", i, {full0, empty0, af0, ae0, ovf0, unf0}, vecs[i].flags);
        end
        push0 = 1'b0; pop0 = 1'b0; ClearErr = 1'b0;

        // wrap-around stream of 20 words with mixed push/pop
        sent = 0; recv = 0; cyc = 0; seen0 = 0; seen1 = 0;
        while (recv < 20 && cyc < 400) begin
            p  = (sent < 20) && ($urandom_range(3) != 0);
            o  = ($urandom_range(2) != 0);
            po = o && (q.size() > 0);
            pu = p && ((q.size() < 8) || po);
            push0 = p; pop0 = o; din0 = 8'(100 + sent);
            tick();
            if (po) begin
                exp_b = q.pop_front();
                chk("wrap_dout", recv, dout0, exp_b);
                recv++;
            end
            if (pu) begin
                q.push_back(8'(100 + sent));
                sent++;
            end
            chk("wrap_count", cyc, count0, q.size());
            if (dut0.wr_ptr_reg[3]) seen1 = 1; else seen0 = 1;
            cyc++;
        end
        push0 = 1'b0; pop0 = 1'b0;
        if (recv != 20) begin
            total++; bad++;
            $display("FAIL wrap_timeout: got %0d words expected 20", recv);
        end
        chk("wrap_msb_toggle", 0, {seen0, seen1}, 2'b11);
        ClearErr = 1'b1;
        tick();
        ClearErr = 1'b0;
        chk("wrap_clr_err", 0, {ovf0, unf0}, 2'b00);

        // FWFT: head word visible without Pop
        push1 = 1'b1; din1 = 8'hA5;
        tick();
        push1 = 1'b0;
        chk("fwft_dout", 0, dout1, 8'hA5);
        chk("fwft_empty", 0, empty1, 1'b0);
        tick();
        chk("fwft_dout", 1, dout1, 8'hA5);
        pop1 = 1'b1;
        tick();
        pop1 = 1'b0;
        chk("fwft_empty", 1, empty1, 1'b1);
        chk("fwft_hold", 0, dout1, 8'hA5);
        push1 = 1'b1; din1 = 8'hB6;
        tick();
        din1 = 8'hC7;
        tick();
        push1 = 1'b0;
        chk("fwft_dout", 2, dout1, 8'hB6);
        chk("fwft_count", 0, count1, 4'd2);
        pop1 = 1'b1;
        tick();
        chk("fwft_dout", 3, dout1, 8'hC7);
        tick();
        pop1 = 1'b0;
        chk("fwft_empty", 2, empty1, 1'b1);
        chk("fwft_hold", 1, dout1, 8'hC7);

        // reset mid-operation: underflow set, 5 words stored
        pop0 = 1'b1;
        tick();
        pop0 = 1'b0;
        chk("mid_unf", 0, unf0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            push0 = 1'b1; din0 = 8'(1 + k);
            tick();
        end
        chk("mid_count", 0, count0, 4'd5);
        Reset = 1'b1; din0 = 8'd9;
        tick();
        Reset = 1'b0; push0 = 1'b0;
        chk("mid_rst_count", 0, count0, 4'd0);
        chk("mid_rst_flags", 0, {full0, empty0, af0, ae0, ovf0, unf0}, 6'b010100);
        chk("mid_rst_dout", 0, dout0, 8'd0);
        for (int k = 0; k < 3; k++) begin
            push0 = 1'b1; din0 = 8'(21 + k);
            tick();
        end
        push0 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            pop0 = 1'b1;
            tick();
            chk("mid_read", k, dout0, 8'(21 + k));
        end
        pop0 = 1'b0;
        tick();
        chk("mid_final_empty", 0, empty0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sync_fifo_flags.md
Name: sync_fifo_flags

Overview:
Single-clock, parametrised successor to the asynchronous FIFO.
- Adds a fill-level count, programmable almost-full and almost-empty thresholds, sticky overflow/underflow error flags, and a selectable first-word-fall-through (FWFT) read mode.
- Sits between same-clock producer and consumer blocks where the clock-domain crossing of the asynchronous FIFO is not needed.
- Depth is 2**AddrSize entries.

Parameters:
DataSize, 8, data word width in bits.
AddrSize, 3, address width; depth = 2**AddrSize (default 8).
AFullThresh, 6, AlmostFull asserts when Count >= AFullThresh; legal range 1..2**AddrSize.
AEmptyThresh, 1, AlmostEmpty asserts when Count <= AEmptyThresh; legal range 0..2**AddrSize-1.
FWFT, 0, read mode; 0 = registered read, 1 = first-word-fall-through.

Ports:
Clk  input  1  single clock; all state updates on the rising edge.
Reset  input  1  synchronous, active-high reset.
Push  input  1  write request.
Pop  input  1  read request.
DataIn  input  DataSize  write data, captured on an accepted Push.
ClearErr  input  1  synchronously clears Overflow and Underflow.
DataOut  output  DataSize  read data.
full  output  1  Count == 2**AddrSize.
empty  output  1  Count == 0.
AlmostFull  output  1  Count >= AFullThresh.
AlmostEmpty  output  1  Count <= AEmptyThresh.
Count  output  AddrSize+1  current number of stored words.
Overflow  output  1  sticky; set by a rejected Push.
Underflow  output  1  sticky; set by a rejected Pop.

Behaviour:
- Clock and reset: one clock, Clk. Reset is synchronous and active-high; it is sampled only on the rising edge of Clk.
- Reset values:
  - WritePtr, ReadPtr and Count are 0.
  - empty=1, full=0, AlmostEmpty=1, AlmostFull=0.
  - DataOut=0, Overflow=0, Underflow=0.
  - Memory contents are not reset.
  - Reset has priority over every other input in the same cycle.
- Pointers:
  - WritePtr and ReadPtr are AddrSize+1 bits wide. The extra MSB is the wrap bit.
  - full is true when the low bits are equal and the MSBs differ; empty is true when the pointers are equal.
  - Pointers increment modulo 2**(AddrSize+1).
- Push acceptance: a Push is accepted when (!full) or (full and a Pop is also accepted that cycle).
  - An accepted Push writes DataIn to mem[WritePtr low bits] and increments WritePtr.
- Pop acceptance: a Pop is accepted when !empty.
  - A Pop while empty is ignored, even if Push is high in the same cycle.
  - An accepted Pop increments ReadPtr.
- Count update:
  - +1 on an accepted Push alone.
  - -1 on an accepted Pop alone.
  - Unchanged when both are accepted, or when neither is.
- Flag timing: all flags are registered functions of the post-edge state. They change on the same edge as Count, one cycle after the request is sampled.
- Errors:
  - A rejected Push sets Overflow on that edge.
  - A rejected Pop sets Underflow on that edge.
  - Both flags hold until ClearErr or Reset.
  - If ClearErr is high in the same cycle as a new error, the flag is set (the set wins).
- FWFT=0 (registered read):
  - On an accepted Pop, DataOut is loaded with mem[ReadPtr] at that edge, so data is visible one cycle after Pop is sampled.
  - DataOut holds its value otherwise.
- FWFT=1 (first-word-fall-through):
  - DataOut is driven from mem[ReadPtr low bits] whenever empty=0, so the head word is visible with no Pop.
  - Pop acknowledges the head word; the next word appears after the edge.
  - While empty=1, DataOut holds its last value.
  - The first word becomes visible the cycle after the Push into an empty FIFO.
- Wrap-around: pointers and memory addressing wrap seamlessly. Data order is preserved across any number of wraps.
- Reset mid-operation: all stored data is discarded. Count returns to 0 and empty=1 on the edge where Reset is sampled high.
- Assertions to bind:
  - never (full and empty) together;
  - Count <= 2**AddrSize;
  - Count == WritePtr - ReadPtr;
  - an accepted Push never occurs while full unless a Pop is also accepted.

Test Plan:
- Fill: with defaults, after Reset push 10,11,...,17 on 8 consecutive cycles. Required: Count steps 1..8; AlmostFull=1 once Count reaches 6; full=1 after the 8th push. A 9th push with value 99 leaves Count=8, sets Overflow=1, and 99 is never read.
- Drain (FWFT=0): from full, pop 8 times. Required: DataOut = 10..17, one cycle after each Pop; empty=1 after the last pop; AlmostEmpty=1 once Count <= 1. One extra Pop sets Underflow=1 and leaves DataOut at 17. ClearErr clears both error flags on the next edge.
- Simultaneous Push+Pop: at full, Push 50 with Pop for one cycle. Required: Count stays 8, full stays 1, no Overflow, and 50 is read last. At empty, Push+Pop: Count becomes 1, Underflow=1.
- Wrap-around: stream 20 words through with mixed Push/Pop patterns. Required: output order equals input order and the pointer MSBs toggle.
- FWFT=1 instance: push 0xA5 into an empty FIFO. Required: DataOut=0xA5 and empty=0 on the next cycle with no Pop; one Pop then gives empty=1.
- Reset mid-operation: with Count=5, assert Reset for one cycle. Required: Count=0, empty=1, Overflow=0, Underflow=0 on that edge; subsequent pushes read back correctly.
